signed_number_32_bit_multiplier: RTL

//   Sequential signed shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH product, one bit per clock.

---
 rtl/signed_number_32_bit_multiplier_if.sv | 23 ++
 rtl/signed_number_32_bit_multiplier.sv | 117 +++++++++++
 2 files changed

// File: rtl/signed_number_32_bit_multiplier_if.sv
// Start/done handshake and operand/result bundle for the sequential signed multiplier.
// The master drives start and operands; the slave (multiplier) returns product, ovf, busy and done.
interface signed_number_32_bit_multiplier_if #(
    parameter int WIDTH = 32
) ();
    logic                 start;
    logic [WIDTH-1:0]     multiplicand;
    logic [WIDTH-1:0]     multiplier;
    logic [2*WIDTH-1:0]   product;
    logic                 ovf;
    logic                 busy;
    logic                 done;

    modport master (
        output start, multiplicand, multiplier,
        input  product, ovf, busy, done
    );

    modport slave (
        input  start, multiplicand, multiplier,
        output product, ovf, busy, done
    );
endinterface

// File: rtl/signed_number_32_bit_multiplier.sv
// Sequential signed shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, one multiplier bit per clock.
// Optional MUL_EARLY_TERM_EN: leave RUN as soon as the remaining multiplier bits are all zero.
module signed_number_32_bit_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic                              clk,
    input  logic                              rst_n,
    signed_number_32_bit_multiplier_if.slave  bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplr_q,  mplr_d;
    logic [2*WIDTH-1:0]   acc_q,   acc_d;
    logic [CW-1:0]        cnt_q,   cnt_d;
    logic                 sign_q,  sign_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic                 ovf_q,   ovf_d;
    logic                 done_q,  done_d;

    logic [WIDTH-1:0]     abs_a, abs_b;
    logic [WIDTH:0]       prod_top;

    // Magnitudes as unsigned WIDTH-bit values; -2^(WIDTH-1) maps to 2^(WIDTH-1).
    assign abs_a    = bus.multiplicand[WIDTH-1] ? (~bus.multiplicand + 1'b1) : bus.multiplicand;
    assign abs_b    = bus.multiplier[WIDTH-1]   ? (~bus.multiplier + 1'b1)   : bus.multiplier;
    assign prod_top = product_d[2*WIDTH-1:WIDTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            mplr_q    <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            sign_q    <= 1'b0;
            product_q <= '0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplr_q    <= mplr_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            sign_q    <= sign_d;
            product_q <= product_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplr_d    = mplr_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        sign_d    = sign_q;
        product_d = product_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    mcand_d = {{WIDTH{1'b0}}, abs_a};
                    mplr_d  = abs_b;
                    sign_d  = bus.multiplicand[WIDTH-1] ^ bus.multiplier[WIDTH-1];
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (mplr_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d = mcand_q << 1;
                mplr_d  = mplr_q >> 1;
                cnt_d   = cnt_q + 1'b1;
`ifdef MUL_EARLY_TERM_EN
                if ((mplr_d == '0) || (cnt_q == LAST)) begin
                    state_d = FINISH;
                end
`else
                if (cnt_q == LAST) begin
                    state_d = FINISH;
                end
`endif
            end
            FINISH: begin
                product_d = sign_q ? (~acc_q + 1'b1) : acc_q;
                // Fits in WIDTH signed bits only when the top WIDTH+1 bits are a pure sign extension.
                ovf_d     = !((prod_top == '0) || (prod_top == '1));
                done_d    = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.product = product_q;
    assign bus.ovf     = ovf_q;
    assign bus.busy    = (state_q != IDLE);
    assign bus.done    = done_q;
endmodule
